// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings, instruction
// length codes and the opcode-to-length rule used by fetch and decode alike.
package fetch_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE = 2'd0;
    localparam fetch_state_t ST_REQ  = 2'd1;
    localparam fetch_state_t ST_DONE = 2'd2;
    localparam fetch_state_t ST_ERR  = 2'd3;

    localparam logic [3:0] LEN_SHORT = 4'd1;
    localparam logic [3:0] LEN_LONG  = 4'd4;

    // Opcode bit 7 selects a 4-byte instruction (opcode + 24-bit immediate).
    function automatic logic [3:0] op_len(input logic [7:0] op);
        return op[7] ? LEN_LONG : LEN_SHORT;
    endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Per-byte wait timer: cleared whenever a new byte is requested, counts
// cycles spent waiting for mem_ack, and flags expiry on the last allowed cycle.
module fetch_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] timer;

    // Count waiting cycles; hold at the last value rather than wrapping.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            timer <= '0;
        end else if (count_en && (timer != LAST)) begin
            timer <= timer + 1'b1;
        end
    end

    assign expire = count_en && (timer == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads an instruction byte-by-byte from instruction
// memory starting at eip, assembles opcode and little-endian immediate, and
// reports the instruction length back to the eip register.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] eip,
    input  logic              fetch_start,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        opcode,
    output logic [23:0]       imm,
    output logic [3:0]        num_of_ope,
    output logic              fetch_done,
    output logic              busy,
    output logic              fetch_err
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] base;
    logic [1:0]        byte_cnt;
    logic              timer_clear;
    logic              timer_en;
    logic              timer_expire;

    // Timer restarts on every new byte request and only runs while waiting.
    assign timer_clear = (state != ST_REQ) || mem_ack;
    assign timer_en    = (state == ST_REQ) && !mem_ack;

    fetch_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .count_en(timer_en),
        .expire  (timer_expire)
    );

    // Fetch FSM and output registers; flush overrides everything but reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            base       <= '0;
            byte_cnt   <= 2'd0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            opcode     <= 8'h00;
            imm        <= 24'h000000;
            num_of_ope <= 4'd0;
        end else if (flush) begin
            state      <= ST_IDLE;
            byte_cnt   <= 2'd0;
            mem_req    <= 1'b0;
            num_of_ope <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fetch_start) begin
                        state      <= ST_REQ;
                        base       <= eip;
                        byte_cnt   <= 2'd0;
                        mem_req    <= 1'b1;
                        mem_addr   <= eip;
                        imm        <= 24'h000000;
                        num_of_ope <= 4'd0;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        if (byte_cnt == 2'd0) begin
                            opcode <= mem_rdata;
                        end
                        case (byte_cnt)
                            2'd1:    imm[7:0]   <= mem_rdata;
                            2'd2:    imm[15:8]  <= mem_rdata;
                            2'd3:    imm[23:16] <= mem_rdata;
                            default: ;
                        endcase
                        if ((byte_cnt == 2'd0) && !mem_rdata[7]) begin
                            state      <= ST_DONE;
                            mem_req    <= 1'b0;
                            num_of_ope <= op_len(mem_rdata);
                        end else if (byte_cnt == 2'd3) begin
                            state      <= ST_DONE;
                            mem_req    <= 1'b0;
                            num_of_ope <= op_len(opcode);
                        end else begin
                            // mem_req stays high so the next byte follows back-to-back.
                            byte_cnt <= byte_cnt + 2'd1;
                            mem_addr <= base + ADDR_W'(byte_cnt) + ADDR_W'(1);
                        end
                    end else if (timer_expire) begin
                        state      <= ST_ERR;
                        mem_req    <= 1'b0;
                        mem_addr   <= '0;
                        opcode     <= 8'h00;
                        imm        <= 24'h000000;
                        num_of_ope <= 4'd0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                ST_ERR: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status pulses decode directly from the state register.
    always_comb begin
        busy       = (state != ST_IDLE);
        fetch_done = (state == ST_DONE) && !flush;
        fetch_err  = (state == ST_ERR);
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a table of single-fetch vectors
// against a byte memory with configurable latency, plus hand-written
// sequences for timeout, flush, reset mid-fetch and ignored requests.
module tb_instr_fetch_unit;

    logic        clock;
    logic        reset;
    logic [31:0] eip;
    logic        fetch_start;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [7:0]  opcode;
    logic [23:0] imm;
    logic [3:0]  num_of_ope;
    logic        fetch_done;
    logic        busy;
    logic        fetch_err;

    instr_fetch_unit #(
        .TIMEOUT_CYCLES(16),
        .ADDR_W        (32)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .eip        (eip),
        .fetch_start(fetch_start),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .opcode     (opcode),
        .imm        (imm),
        .num_of_ope (num_of_ope),
        .fetch_done (fetch_done),
        .busy       (busy),
        .fetch_err  (fetch_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Byte memory indexed by the low 12 address bits (all test addresses differ there).
    logic [7:0] mem [4096];
    int         lat;
    logic       ack_en;
    logic       force_ack;
    logic       req_seen;
    int         wcnt;

    // lat = cycles per byte once the request is registered; first byte has one extra.
    always @(posedge clock) begin
        req_seen <= mem_req && !reset;
        if (reset || !mem_req || mem_ack || !req_seen) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    assign mem_ack = force_ack || (ack_en && mem_req && req_seen && (wcnt >= lat - 1));
    always_comb mem_rdata = mem[mem_addr[11:0]];

    int          n_cmp;
    int          n_bad;
    int          done_cyc;
    int          n_ack;
    logic [31:0] addr_log [8];

    typedef struct {
        logic [31:0] eip;
        logic [7:0]  b0, b1, b2, b3;
        int          lat;
        logic [7:0]  opc;
        logic [23:0] imm;
        logic [3:0]  len;
        int          done;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic load4(input logic [31:0] a, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        logic [31:0] x;
        x = a;      mem[x[11:0]] = b0;
        x = a + 1;  mem[x[11:0]] = b1;
        x = a + 2;  mem[x[11:0]] = b2;
        x = a + 3;  mem[x[11:0]] = b3;
    endtask

    // Called at a negedge inside cycle start_c; samples each negedge until fetch_done.
    task automatic wait_done(input int start_c);
        done_cyc = -1;
        n_ack    = 0;
        for (int c = start_c; c <= 60; c++) begin
            if (mem_req && mem_ack) begin
                if (n_ack < 8) addr_log[n_ack] = mem_addr;
                n_ack++;
            end
            if (fetch_done) begin
                done_cyc = c;
                break;
            end
            @(negedge clock);
        end
    endtask

    // Pulses fetch_start in cycle 0 (from a negedge) and waits for completion.
    task automatic run_fetch(input logic [31:0] e);
        eip         = e;
        fetch_start = 1'b1;
        @(negedge clock);
        fetch_start = 1'b0;
        wait_done(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int err_cyc;
        int saw_done;
        logic [31:0] a;

        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        reset = 1'b1; eip = '0; fetch_start = 1'b0; flush = 1'b0;
        lat = 1; ack_en = 1'b1; force_ack = 1'b0;

        vecs[0] = '{32'h0000_0010, 8'h05, 8'h00, 8'h00, 8'h00, 1, 8'h05, 24'h000000, 4'd1, 3};
        vecs[1] = '{32'h0000_0020, 8'h81, 8'h11, 8'h22, 8'h33, 1, 8'h81, 24'h332211, 4'd4, 6};
        vecs[2] = '{32'hFFFF_FFFE, 8'h90, 8'hAA, 8'hBB, 8'hCC, 1, 8'h90, 24'hCCBBAA, 4'd4, 6};
        vecs[3] = '{32'h0000_0100, 8'h7F, 8'h00, 8'h00, 8'h00, 3, 8'h7F, 24'h000000, 4'd1, 5};
        vecs[4] = '{32'h0000_0200, 8'hFF, 8'h01, 8'h02, 8'h03, 3, 8'hFF, 24'h030201, 4'd4, 14};

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_opcode", {24'd0, opcode}, 32'd0);
        check("rst_imm", {8'd0, imm}, 32'd0);
        check("rst_num_of_ope", {28'd0, num_of_ope}, 32'd0);
        check("rst_flags", {29'd0, fetch_done, busy, fetch_err}, 32'd0);

        // Table of single fetches.
        for (int i = 0; i < 5; i++) begin
            load4(vecs[i].eip, vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
            lat = vecs[i].lat;
            run_fetch(vecs[i].eip);
            check($sformatf("v%0d_done_cycle", i), 32'(done_cyc), 32'(vecs[i].done));
            check($sformatf("v%0d_opcode", i), {24'd0, opcode}, {24'd0, vecs[i].opc});
            check($sformatf("v%0d_imm", i), {8'd0, imm}, {8'd0, vecs[i].imm});
            check($sformatf("v%0d_len", i), {28'd0, num_of_ope}, {28'd0, vecs[i].len});
            check($sformatf("v%0d_n_bytes", i), 32'(n_ack), {28'd0, vecs[i].len});
            for (int k = 0; k < int'(vecs[i].len); k++) begin
                a = vecs[i].eip + 32'(k);
                if (k < n_ack) check($sformatf("v%0d_addr%0d", i, k), addr_log[k], a);
            end
            @(negedge clock);
            check($sformatf("v%0d_after_flags", i), {30'd0, fetch_done, busy}, 32'd0);
            check($sformatf("v%0d_len_held", i), {28'd0, num_of_ope}, {28'd0, vecs[i].len});
        end

        // Timeout: memory never acks.
        lat = 1;
        ack_en = 1'b0;
        eip = 32'h0000_0300;
        fetch_start = 1'b1;
        @(negedge clock);
        fetch_start = 1'b0;
        err_cyc = -1;
        saw_done = 0;
        for (int c = 1; c <= 40; c++) begin
            if (fetch_done) saw_done = 1;
            if (fetch_err) begin
                err_cyc = c;
                break;
            end
            @(negedge clock);
        end
        check("to_err_cycle", 32'(err_cyc), 32'd17);
        check("to_no_done", 32'(saw_done), 32'd0);
        check("to_mem_req", {31'd0, mem_req}, 32'd0);
        check("to_num_of_ope", {28'd0, num_of_ope}, 32'd0);
        check("to_opcode", {24'd0, opcode}, 32'd0);
        @(negedge clock);
        check("to_after_flags", {30'd0, busy, fetch_err}, 32'd0);
        ack_en = 1'b1;

        // Flush on the cycle the second byte acks, then an immediate new fetch.
        load4(32'h0000_0040, 8'h81, 8'h44, 8'h55, 8'h66);
        eip = 32'h0000_0020;
        fetch_start = 1'b1;
        @(negedge clock);
        fetch_start = 1'b0;
        saw_done = 0;
        @(negedge clock);
        if (fetch_done) saw_done = 1;
        @(negedge clock);
        check("fl_ack_addr", {mem_ack, mem_addr[30:0]}, {1'b1, 31'h21});
        flush = 1'b1;
        if (fetch_done) saw_done = 1;
        @(negedge clock);
        flush = 1'b0;
        if (fetch_done) saw_done = 1;
        check("fl_no_done", 32'(saw_done), 32'd0);
        check("fl_idle", {30'd0, busy, mem_req}, 32'd0);
        check("fl_num_of_ope", {28'd0, num_of_ope}, 32'd0);
        run_fetch(32'h0000_0040);
        check("fl_new_done_cycle", 32'(done_cyc), 32'd6);
        check("fl_new_opcode", {24'd0, opcode}, 32'h81);
        check("fl_new_imm", {8'd0, imm}, 32'h665544);
        check("fl_new_len", {28'd0, num_of_ope}, 32'd4);
        @(negedge clock);

        // Flush together with fetch_start in IDLE: no fetch, length cleared.
        eip = 32'h0000_0010;
        fetch_start = 1'b1;
        flush = 1'b1;
        @(negedge clock);
        fetch_start = 1'b0;
        flush = 1'b0;
        check("flst_idle", {30'd0, busy, mem_req}, 32'd0);
        check("flst_num_of_ope", {28'd0, num_of_ope}, 32'd0);
        @(negedge clock);
        check("flst_still_idle", {31'd0, busy}, 32'd0);

        // fetch_start held into the busy cycle with a different eip is ignored.
        eip = 32'h0000_0020;
        fetch_start = 1'b1;
        @(negedge clock);
        eip = 32'h0000_0040;
        @(negedge clock);
        fetch_start = 1'b0;
        wait_done(2);
        check("bz_done_cycle", 32'(done_cyc), 32'd6);
        check("bz_first_addr", addr_log[0], 32'h20);
        check("bz_imm", {8'd0, imm}, 32'h332211);
        @(negedge clock);
        check("bz_idle_after", {31'd0, busy}, 32'd0);

        // Reset for one cycle mid-fetch, then a 3-cycle-per-byte memory.
        load4(32'h0000_0500, 8'h81, 8'h12, 8'h34, 8'h56);
        lat = 1;
        eip = 32'h0000_0020;
        fetch_start = 1'b1;
        @(negedge clock);
        fetch_start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mr_outputs", {mem_req, mem_addr[22:0], opcode}, 32'd0);
        check("mr_imm_len", {4'd0, imm, num_of_ope}, 32'd0);
        check("mr_flags", {29'd0, fetch_done, busy, fetch_err}, 32'd0);
        lat = 3;
        run_fetch(32'h0000_0500);
        check("mr_done_cycle", 32'(done_cyc), 32'd14);
        check("mr_opcode", {24'd0, opcode}, 32'h81);
        check("mr_imm", {8'd0, imm}, 32'h563412);
        check("mr_len", {28'd0, num_of_ope}, 32'd4);
        @(negedge clock);

        // mem_ack with no request outstanding changes nothing.
        force_ack = 1'b1;
        @(negedge clock);
        @(negedge clock);
        force_ack = 1'b0;
        check("ia_idle", {30'd0, busy, mem_req}, 32'd0);
        check("ia_opcode_held", {24'd0, opcode}, 32'h81);
        check("ia_len_held", {28'd0, num_of_ope}, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Reads the instruction at the current eip from byte-wide instruction memory, one byte per handshake.
- Determines the instruction length and assembles opcode plus immediate.
- Reports the length on num_of_ope back to the eip register, which adds 1 or 4 after the instruction.
- Sits between the eip register and instruction memory, ahead of decode/execute.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles to wait for mem_ack per byte before error.
- ADDR_W, 32: address/eip width.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- eip  in  ADDR_W  address of first instruction byte; sampled on fetch_start.
- fetch_start  in  1  one-cycle request to fetch the instruction at eip.
- flush  in  1  cancels any in-flight fetch (jump/eip rewrite).
- mem_req  out  1  byte read request; held until mem_ack.
- mem_addr  out  ADDR_W  byte address; stable while mem_req=1.
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  8  read byte.
- opcode  out  8  fetched opcode.
- imm  out  24  immediate bytes, little-endian; 0 for 1-byte instructions.
- num_of_ope  out  4  instruction length: 4'd1 or 4'd4; 4'd0 when no valid instruction.
- fetch_done  out  1  one-cycle pulse; outputs valid.
- busy  out  1  high in any state other than IDLE.
- fetch_err  out  1  one-cycle pulse on timeout; other outputs held at 0.

Behaviour:
- Reset: state IDLE; mem_req=0, mem_addr=0, opcode=0, imm=0, num_of_ope=0, fetch_done=0, busy=0, fetch_err=0, byte_cnt=0, timer=0.
- Reset asserted mid-fetch returns to IDLE the next edge and discards the partial instruction.
- FSM states:
  - IDLE: on fetch_start, latch base=eip, set byte_cnt=0, drive mem_req=1 with mem_addr=eip, go to REQ.
  - REQ: wait for mem_ack.
    - On mem_ack with byte_cnt=0: opcode<=mem_rdata. If mem_rdata[7]=1, total length is 4; else length 1 and go to DONE.
    - On mem_ack with byte_cnt=1..3: imm[8*(byte_cnt-1)+:8]<=mem_rdata.
    - After the 4th byte, go to DONE.
    - Otherwise byte_cnt+1; mem_addr <= base+byte_cnt+1, modulo 2^ADDR_W, wrapping 0xFFFFFFFF to 0x00000000.
    - mem_req stays high across back-to-back bytes; each byte costs at least one cycle.
  - DONE: fetch_done=1 for one cycle; num_of_ope=1 or 4; go to IDLE.
    - opcode/imm/num_of_ope stay held until the next fetch_start or flush, which clears num_of_ope to 0.
  - ERR: fetch_err=1 for one cycle; clear opcode, imm, num_of_ope; go to IDLE.
- Timeout: timer resets on each byte request and increments each REQ cycle without mem_ack. At timer==TIMEOUT_CYCLES-1 with no ack, go to ERR and drop mem_req.
- Latency with zero-wait memory (mem_ack on the cycle after the request): fetch_start to fetch_done is 3 cycles for a 1-byte instruction and 6 for a 4-byte one.
- flush: highest priority after reset.
  - In any state, next state is IDLE, mem_req=0, num_of_ope=0, and no fetch_done.
  - A mem_ack arriving in the same cycle as flush is ignored.
  - flush together with fetch_start in IDLE: flush wins; no fetch starts.
- fetch_start while busy is ignored.
- mem_ack while mem_req=0 is ignored.
- num_of_ope is never 2 or 3. The eip register treats 0 as "no increment".

Decomposition:
- Package fetch_pkg:
  - State enum (IDLE, REQ, DONE, ERR).
  - Length constants LEN_SHORT=4'd1, LEN_LONG=4'd4.
  - Function op_len(opcode) returning the length from bit 7, so decode can share the rule.
- One sub-module, fetch_timeout_counter: load/clear/expire on TIMEOUT_CYCLES. All else inline.

Test Plan:
- eip=0x10, mem[0x10]=0x05, zero-wait, pulse fetch_start -> mem_addr=0x10 once; fetch_done at cycle 3; opcode=0x05, imm=0, num_of_ope=1.
- eip=0x20, mem=0x81,0x11,0x22,0x33 -> addresses 0x20..0x23 in order; opcode=0x81, imm=0x332211, num_of_ope=4; done at cycle 6.
- eip=0xFFFFFFFE, 4-byte opcode -> addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001; num_of_ope=4.
- mem_ack withheld 16 cycles after the first request -> fetch_err pulse on the 16th waiting cycle; mem_req=0; num_of_ope=0; busy=0 next cycle.
- flush asserted on the cycle the 2nd byte acks -> no fetch_done; IDLE next edge; immediate new fetch_start at eip=0x40 completes normally.
- reset asserted mid-fetch for one cycle -> all outputs 0 the next cycle; a 3-wait-state memory then fetches 0x81 correctly with done at cycle 14.
